// File: rtl/fault_inject_ctrl.sv
// Campaign controller for single-bit fault injection on a registered data
// stream. A campaign of num_inj injections, spaced by gap idle cycles, flips
// one LFSR-selected bit of the next valid word at each injection slot. The
// data path always has a fixed one-cycle latency and is never stalled.
module fault_inject_ctrl #(
   parameter int unsigned W     = 16,      // data width: 4, 8, 16 or 32
   parameter int unsigned CNT_W = 8,       // injection count width
   parameter int unsigned GAP_W = 16,      // inter-injection gap width
   parameter logic [15:0] SEED  = 16'hACE1 // LFSR reset value, nonzero
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [CNT_W-1:0]       num_inj,
   input  logic [GAP_W-1:0]       gap,
   input  logic [W-1:0]           data_in,
   input  logic                   data_valid,
   output logic [W-1:0]           data_out,
   output logic                   data_out_valid,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       inj_count,
   output logic [$clog2(W)-1:0]   last_pos
);

   localparam int unsigned PW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ARMED = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  remaining, remaining_nxt;
   logic [GAP_W-1:0]  gap_reg, gap_reg_nxt;
   logic [GAP_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  inj_count_nxt;
   logic [PW-1:0]     last_pos_nxt;
   logic [15:0]       lfsr;
   logic              lfsr_fb;
   logic [PW-1:0]     pos;
   logic              inject;
   logic [W-1:0]      flip_mask;

   // Bit position for an injection comes from the current (pre-shift) LFSR.
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign pos     = lfsr[PW-1:0];

   // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1; advances every cycle
   // regardless of campaign state.
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of the others, independent of
   // statement order; blocking assignments here would create order-dependent
   // races in simulation and can mismatch the synthesised netlist.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   // Next-state and campaign bookkeeping; abort overrides everything,
   // including a start in the same cycle and an injection in ARMED.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      gap_reg_nxt   = gap_reg;
      cnt_nxt       = cnt;
      inj_count_nxt = inj_count;
      last_pos_nxt  = last_pos;
      inject        = 1'b0;

      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  remaining_nxt = num_inj;
                  gap_reg_nxt   = gap;
                  cnt_nxt       = gap;
                  inj_count_nxt = '0;
                  state_nxt     = (num_inj != '0) ? S_WAIT : S_DONE;
               end
            end
            S_WAIT: begin
               // WAIT lasts gap+1 cycles: gap decrements plus the exit cycle.
               if (cnt == '0) begin
                  state_nxt = S_ARMED;
               end else begin
                  cnt_nxt = cnt - GAP_W'(1);
               end
            end
            S_ARMED: begin
               // Hold until a valid word shows up, then flip one of its bits.
               if (data_valid) begin
                  inject        = 1'b1;
                  inj_count_nxt = inj_count + CNT_W'(1);
                  last_pos_nxt  = pos;
                  remaining_nxt = remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state_nxt = S_DONE;
                  end else begin
                     cnt_nxt   = gap_reg;
                     state_nxt = S_WAIT;
                  end
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // One-hot flip mask for the word being injected this cycle.
   always_comb begin
      flip_mask = '0;
      if (inject) begin
         flip_mask[pos] = 1'b1;
      end
   end

   // Campaign state registers; busy and done are registered alongside the
   // state so they are glitch-free and aligned with it.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= S_IDLE;
         remaining <= '0;
         gap_reg   <= '0;
         cnt       <= '0;
         inj_count <= '0;
         last_pos  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         gap_reg   <= gap_reg_nxt;
         cnt       <= cnt_nxt;
         inj_count <= inj_count_nxt;
         last_pos  <= last_pos_nxt;
         busy      <= (state_nxt == S_WAIT) || (state_nxt == S_ARMED);
         done      <= (state_nxt == S_DONE);
      end
   end

   // Inline data register: fixed one-cycle latency, optional single-bit flip.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out       <= data_in ^ flip_mask;
         data_out_valid <= data_valid;
      end
   end

endmodule
